// File: rtl/red_pitaya_dac_slew_pkg.sv
// Shared types and helpers for the DAC slew-rate limiter / park stage.
`default_nettype none

package red_pitaya_dac_slew_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PARK   = 2'd1,
        PARKED = 2'd2
    } slew_st_t;

    localparam logic [13:0] DAC_MID = 14'h2000;

    // Two's complement to offset binary: flipping the sign bit maps 0 to mid-scale.
    function automatic logic [13:0] to_offset_bin(input logic signed [13:0] val);
        return {~val[13], val[12:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/red_pitaya_dac_slew_ch.sv
// One DAC channel: rate-of-change limiter with ramp-to-zero park control.
`default_nettype none

module red_pitaya_dac_slew_ch
    import red_pitaya_dac_slew_pkg::*;
#(
    parameter int DAC_DW = 14,
    parameter int SLW    = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DAC_DW-1:0] dat,
    input  logic        [SLW-1:0]    slew,
    input  logic                     park,
    output logic        [DAC_DW-1:0] dac,
    output logic                     lim,
    output logic                     parked
);

    slew_st_t                 state;
    slew_st_t                 state_next;
    logic signed [DAC_DW-1:0] y;
    logic signed [DAC_DW-1:0] y_next;
    logic signed [DAC_DW-1:0] tgt;
    logic signed [DAC_DW:0]   diff;
    logic signed [DAC_DW:0]   mag;
    logic signed [DAC_DW:0]   slew_ext;
    logic signed [DAC_DW:0]   step_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (park) state_next = PARK;
            PARK: begin
                // Releasing park takes priority over landing on zero.
                if (!park)             state_next = RUN;
                else if (y_next == '0) state_next = PARKED;
            end
            PARKED:  if (!park) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        parked = (state == PARKED);
    end

    // Step arithmetic is one bit wider so a full-scale swing (|d| = 2^DAC_DW - 1) is exact.
    always_comb begin
        tgt      = (state == RUN) ? dat : '0;
        slew_ext = signed'({{(DAC_DW + 1 - SLW){1'b0}}, slew});
        diff     = {tgt[DAC_DW-1], tgt} - {y[DAC_DW-1], y};
        mag      = (diff < 0) ? -diff : diff;
        step_sum = '0;
        if ((slew == '0) || (mag <= slew_ext)) begin
            y_next = tgt;
        end else begin
            if (diff > 0) step_sum = {y[DAC_DW-1], y} + slew_ext;
            else          step_sum = {y[DAC_DW-1], y} - slew_ext;
            y_next = step_sum[DAC_DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y   <= '0;
            dac <= DAC_MID;
            lim <= 1'b0;
        end else begin
            y   <= y_next;
            dac <= to_offset_bin(y_next);
            lim <= (tgt != y_next);
        end
    end

endmodule

`default_nettype wire

// File: rtl/red_pitaya_dac_slew.sv
// Dual-channel DAC output conditioning: slew limiting, park ramp, offset-binary coding.
`default_nettype none

module red_pitaya_dac_slew
    import red_pitaya_dac_slew_pkg::*;
#(
    parameter int DAC_DW = 14,
    parameter int SLW    = 14
) (
    input  logic                     dac_clk_i,
    input  logic                     dac_rst_i,
    input  logic signed [DAC_DW-1:0] dat_a_i,
    input  logic signed [DAC_DW-1:0] dat_b_i,
    input  logic        [SLW-1:0]    slew_a_i,
    input  logic        [SLW-1:0]    slew_b_i,
    input  logic                     park_a_i,
    input  logic                     park_b_i,
    output logic        [DAC_DW-1:0] dac_a_o,
    output logic        [DAC_DW-1:0] dac_b_o,
    output logic                     lim_a_o,
    output logic                     lim_b_o,
    output logic                     parked_a_o,
    output logic                     parked_b_o
);

    red_pitaya_dac_slew_ch #(.DAC_DW(DAC_DW), .SLW(SLW)) u_ch_a (
        .clk    (dac_clk_i),
        .rst    (dac_rst_i),
        .dat    (dat_a_i),
        .slew   (slew_a_i),
        .park   (park_a_i),
        .dac    (dac_a_o),
        .lim    (lim_a_o),
        .parked (parked_a_o)
    );

    red_pitaya_dac_slew_ch #(.DAC_DW(DAC_DW), .SLW(SLW)) u_ch_b (
        .clk    (dac_clk_i),
        .rst    (dac_rst_i),
        .dat    (dat_b_i),
        .slew   (slew_b_i),
        .park   (park_b_i),
        .dac    (dac_b_o),
        .lim    (lim_b_o),
        .parked (parked_b_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_dac_slew.sv
// Self-checking bench for red_pitaya_dac_slew: directed plan plus randomized model comparison.
`default_nettype none

module tb_red_pitaya_dac_slew;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] dat_a = '0, dat_b = '0;
    logic [13:0] slew_a = '0, slew_b = '0;
    logic        park_a = 1'b0, park_b = 1'b0;
    logic [13:0] dac_a, dac_b;
    logic        lim_a, lim_b, parked_a, parked_b;

    int tests = 0;
    int fails = 0;

    // Model state: y as integer, st 0=RUN 1=PARK 2=PARKED.
    int ya, yb, sta, stb, lima, limb;

    always #4 clk = ~clk;

    red_pitaya_dac_slew dut (
        .dac_clk_i  (clk),
        .dac_rst_i  (rst),
        .dat_a_i    (dat_a),
        .dat_b_i    (dat_b),
        .slew_a_i   (slew_a),
        .slew_b_i   (slew_b),
        .park_a_i   (park_a),
        .park_b_i   (park_b),
        .dac_a_o    (dac_a),
        .dac_b_o    (dac_b),
        .lim_a_o    (lim_a),
        .lim_b_o    (lim_b),
        .parked_a_o (parked_a),
        .parked_b_o (parked_b)
    );

    function automatic logic [13:0] code(input int y);
        int v;
        v = y + 8192;
        return v[13:0];
    endfunction

    function automatic int sx(input logic [13:0] v);
        return (v >= 14'd8192) ? int'(v) - 16384 : int'(v);
    endfunction

    task automatic model_ch(input int dat, input int slew, input int park,
                            inout int y, inout int st, inout int lim);
        int t, d, ad, yn, sn;
        t  = (st == 0) ? dat : 0;
        d  = t - y;
        ad = (d < 0) ? -d : d;
        if (slew == 0 || ad <= slew) yn = t;
        else                         yn = (d > 0) ? y + slew : y - slew;
        case (st)
            0:       sn = park ? 1 : 0;
            1:       sn = !park ? 0 : ((yn == 0) ? 2 : 1);
            default: sn = park ? 2 : 0;
        endcase
        lim = (t != yn) ? 1 : 0;
        y   = yn;
        st  = sn;
    endtask

    task automatic model_reset();
        ya = 0; yb = 0; sta = 0; stb = 0; lima = 0; limb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_ch(sx(dat_a), int'(slew_a), int'(park_a), ya, sta, lima);
        model_ch(sx(dat_b), int'(slew_b), int'(park_b), yb, stb, limb);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dat_a = '0; dat_b = '0; slew_a = '0; slew_b = '0; park_a = 0; park_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (dac_a !== 14'h2000 || lim_a !== 1'b0 || parked_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_a: dac=%h lim=%b parked=%b want 2000/0/0", dac_a, lim_a, parked_a);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests++;
        if (dac_a !== 14'h2000 || lim_a !== 1'b0 || parked_a !== 1'b0 || dac_b !== 14'h2000) begin
            fails++;
            $display("FAIL reset_run: dac_a=%h lim=%b parked=%b dac_b=%h want 2000/0/0/2000",
                     dac_a, lim_a, parked_a, dac_b);
        end
    endtask

    task automatic test_bypass();
        slew_a = '0;
        dat_a  = 14'd5000;
        tick();
        tests++;
        if (dac_a !== 14'h3388 || lim_a !== 1'b0) begin
            fails++;
            $display("FAIL bypass: dac=%h lim=%b want 3388/0", dac_a, lim_a);
        end
    endtask

    task automatic test_limited_rise();
        dat_a = '0; slew_a = '0;
        tick();
        slew_a = 14'd1000;
        dat_a  = 14'd5000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests++;
            if (dac_a !== code(i * 1000) || lim_a !== ((i < 5) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL rise_%0d: dac=%h lim=%b want %h/%0d", i, dac_a, lim_a,
                         code(i * 1000), (i < 5) ? 1 : 0);
            end
        end
    endtask

    task automatic test_full_scale_neg();
        int exp_y[4] = '{4095, -1, -4097, -8192};
        slew_a = '0; dat_a = 14'd8191;
        tick();
        slew_a = 14'd4096; dat_a = 14'h2000;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (dac_a !== code(exp_y[i])) begin
                fails++;
                $display("FAIL fullneg_%0d: dac=%h want %h", i, dac_a, code(exp_y[i]));
            end
        end
        tests++;
        if (dac_a !== 14'h0000 || lim_a !== 1'b0) begin
            fails++;
            $display("FAIL fullneg_final: dac=%h lim=%b want 0000/0", dac_a, lim_a);
        end
    endtask

    task automatic test_park();
        int exp_y[5] = '{2300, 1600, 900, 200, 0};
        slew_a = '0; dat_a = 14'd3000;
        tick();
        slew_a = 14'd700; park_a = 1'b1;
        tick();
        tests++;
        if (dac_a !== code(3000) || parked_a !== 1'b0) begin
            fails++;
            $display("FAIL park_enter: dac=%h parked=%b want %h/0", dac_a, parked_a, code(3000));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (dac_a !== code(exp_y[i]) || parked_a !== ((i == 4) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL park_ramp_%0d: dac=%h parked=%b want %h/%0d", i, dac_a,
                         parked_a, code(exp_y[i]), (i == 4) ? 1 : 0);
            end
        end
        park_a = 1'b0; dat_a = 14'd700;
        tick();
        tests++;
        if (parked_a !== 1'b0) begin
            fails++;
            $display("FAIL unpark_flag: parked=%b want 0", parked_a);
        end
        tick();
        tests++;
        if (dac_a !== code(700) || parked_a !== 1'b0) begin
            fails++;
            $display("FAIL unpark_value: dac=%h parked=%b want %h/0", dac_a, parked_a, code(700));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            dat_a = 14'($urandom_range(0, 16383));
            dat_b = 14'($urandom_range(0, 16383));
            case ($urandom_range(0, 3))
                0:       slew_a = '0;
                1:       slew_a = 14'($urandom_range(1, 16383));
                default: slew_a = 14'($urandom_range(1, 600));
            endcase
            slew_b = ($urandom_range(0, 4) == 0) ? 14'd0 : 14'($urandom_range(1, 3000));
            if ($urandom_range(0, 15) == 0) park_a = ~park_a;
            if ($urandom_range(0, 15) == 0) park_b = ~park_b;
            tick();
            tests++;
            if (dac_a !== code(ya) || lim_a !== lima[0] || parked_a !== (sta == 2) ||
                dac_b !== code(yb) || lim_b !== limb[0] || parked_b !== (stb == 2)) begin
                fails++;
                $display("FAIL random_%0d: a=%h/%b/%b want %h/%0d/%0d b=%h/%b/%b want %h/%0d/%0d",
                         c, dac_a, lim_a, parked_a, code(ya), lima, (sta == 2),
                         dac_b, lim_b, parked_b, code(yb), limb, (stb == 2));
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        park_a = 1'b0; slew_a = 14'd100; dat_a = 14'd0;
        park_b = 1'b1; slew_b = 14'd500; dat_b = 14'd1000;
        guard = 0;
        while (stb != 2 && guard < 100) begin
            tick();
            guard++;
        end
        tests++;
        if (parked_b !== 1'b1) begin
            fails++;
            $display("FAIL indep_parked_b: parked=%b want 1 (cycles %0d)", parked_b, guard);
        end
        dat_a = 14'd5000;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (dac_a !== code(ya) || lim_a !== lima[0] || parked_b !== 1'b1 || dac_b !== 14'h2000) begin
                fails++;
                $display("FAIL indep_%0d: dac_a=%h lim=%b want %h/%0d, parked_b=%b dac_b=%h want 1/2000",
                         i, dac_a, lim_a, code(ya), lima, parked_b, dac_b);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        tests++;
        if (dac_a !== 14'h2000 || dac_b !== 14'h2000 || parked_b !== 1'b0 || lim_a !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: dac_a=%h dac_b=%h parked_b=%b lim_a=%b want 2000/2000/0/0",
                     dac_a, dac_b, parked_b, lim_a);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (dac_a !== code(ya) || dac_b !== code(yb) || parked_b !== (stb == 2)) begin
                fails++;
                $display("FAIL post_reset_%0d: dac_a=%h dac_b=%h parked_b=%b want %h/%h/%0d",
                         i, dac_a, dac_b, parked_b, code(ya), code(yb), (stb == 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_limited_rise();
        test_full_scale_neg();
        test_park();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
